// File: rtl/mano_loader.sv
// mano_loader: framed byte-stream program loader for the Mano CPU load port.
// Optional trailer checksum enabled by defining LOADER_CHECKSUM_EN.
module mano_loader #(
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [ADDR_W-1:0] address,
   output logic [15:0]       code,
   output logic              wr,
   output logic              run_code,
   output logic              busy,
   output logic              err
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_ADDR_HI,
      S_ADDR_LO,
      S_CNT_HI,
      S_CNT_LO,
      S_DATA_HI,
      S_DATA_LO,
      S_FLUSH,
`ifdef LOADER_CHECKSUM_EN
      S_CHK,
`endif
      S_RUN
   } state_t;

`ifdef LOADER_CHECKSUM_EN
   localparam state_t P_DONE = S_CHK;
`else
   localparam state_t P_DONE = S_RUN;
`endif

   state_t            r_state;
   state_t            w_next;
   logic [7:0]        r_hi;
   logic [ADDR_W-1:0] r_ptr;
   logic [ADDR_W-1:0] r_cnt;
   logic [ADDR_W-1:0] r_address;
   logic [15:0]       r_code;
   logic              r_wr;
   logic              r_err;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]        r_sum;
`endif

   logic              w_take;
   logic [ADDR_W-1:0] w_field;
   logic              w_last;

   assign w_take   = in_valid && in_ready;
   assign w_field  = ADDR_W'({r_hi, in_data});
   assign w_last   = (r_cnt == ADDR_W'(1));
   assign address  = r_address;
   assign code     = r_code;
   assign wr       = r_wr;
   assign err      = r_err;

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (load) begin
         w_next = S_ADDR_HI;
      end else begin
         unique case (r_state)
            S_ADDR_HI: if (w_take) w_next = S_ADDR_LO;
            S_ADDR_LO: if (w_take) w_next = S_CNT_HI;
            S_CNT_HI:  if (w_take) w_next = S_CNT_LO;
            S_CNT_LO:
               if (w_take)
                  w_next = (w_field == '0) ? P_DONE : S_DATA_HI;
            S_DATA_HI: if (w_take) w_next = S_DATA_LO;
            S_DATA_LO:
               if (w_take)
                  w_next = w_last ? S_FLUSH : S_DATA_HI;
            S_FLUSH:   w_next = P_DONE;
`ifdef LOADER_CHECKSUM_EN
            S_CHK:
               if (w_take)
                  w_next = (in_data == r_sum) ? S_RUN : S_IDLE;
`endif
            default:   w_next = r_state;
         endcase
      end
   end

   always_comb begin
      in_ready = 1'b0;
      busy     = 1'b1;
      run_code = 1'b0;
      unique case (r_state)
         S_IDLE:  busy = 1'b0;
         S_RUN: begin
            busy     = 1'b0;
            run_code = 1'b1;
         end
         S_FLUSH: in_ready = 1'b0;
         default: in_ready = !load;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_hi      <= '0;
         r_ptr     <= '0;
         r_cnt     <= '0;
         r_address <= '0;
         r_code    <= '0;
         r_wr      <= 1'b0;
         r_err     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         r_sum     <= '0;
`endif
      end else begin
         r_wr <= 1'b0;
         if (load) begin
            r_err <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_sum <= '0;
`endif
         end else if (w_take) begin
            unique case (r_state)
               S_ADDR_HI, S_CNT_HI: r_hi <= in_data;
               S_ADDR_LO: r_ptr <= w_field;
               S_CNT_LO:  r_cnt <= w_field;
               S_DATA_HI: begin
                  r_hi <= in_data;
`ifdef LOADER_CHECKSUM_EN
                  r_sum <= r_sum + in_data;
`endif
               end
               S_DATA_LO: begin
                  r_wr      <= 1'b1;
                  r_address <= r_ptr;
                  r_code    <= {r_hi, in_data};
                  r_ptr     <= r_ptr + ADDR_W'(1);
                  r_cnt     <= r_cnt - ADDR_W'(1);
                  // pointer wrapping past the top of memory is flagged
                  if (r_ptr == '1) r_err <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                  r_sum <= r_sum + in_data;
`endif
               end
`ifdef LOADER_CHECKSUM_EN
               S_CHK: if (in_data != r_sum) r_err <= 1'b1;
`endif
               default: ;
            endcase
         end
      end
   end

endmodule
